disp_scan_ctrl: RTL and testbench

Time-multiplexed display scan controller that sits directly upstream of the 2-to-4 decoder. It cycles a 2-bit digit index through four slots at a fixed rate. That index drives the decoder's select (`a`) and enable (`en`) inputs, which light one digit line at a time. It also presents the matching 8-bit segment pattern, and blanks the start of each slot to suppress ghosting.

---
 rtl/disp_scan_ctrl.sv | 107 ++++++++++
 tb/tb_disp_scan_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/disp_scan_ctrl.sv
`default_nettype none
// ============================================================================
// disp_scan_ctrl
//   Four-slot display scan controller that feeds a 2-to-4 decoder. It drives
//   a slot index, a registered segment pattern and a blanked decoder enable.
// Revision: 1.0
// ============================================================================
module disp_scan_ctrl #(
   parameter int DIV   = 50000,
   parameter int BLANK = 4
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [7:0] in0,
   input  logic [7:0] in1,
   input  logic [7:0] in2,
   input  logic [7:0] in3,
   input  logic [3:0] mask,
   input  logic       en_in,
   output logic [1:0] sel,
   output logic       dec_en,
   output logic [7:0] seg,
   output logic       slot_tick
);

   localparam int            CW         = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] C_CNT_LAST = CW'(DIV - 1);
   localparam logic [CW-1:0] C_BLANK    = CW'(BLANK);

   typedef enum logic [0:0] {
      S_BLANK = 1'b0,
      S_SHOW  = 1'b1
   } phase_t;

   phase_t          r_phase;
   phase_t          w_phase_next;
   logic [CW-1:0]   r_cnt;
   logic [CW-1:0]   w_cnt_next;
   logic            w_wrap;
   logic [1:0]      r_sel;
   logic [1:0]      w_sel_next;
   logic [7:0]      r_seg;
   logic [7:0]      w_in_next;
   logic            r_mask;
   logic            r_en;
   logic            r_tick;

   assign w_wrap     = (r_cnt == C_CNT_LAST);
   assign w_cnt_next = w_wrap ? '0 : r_cnt + 1'b1;
   assign w_sel_next = r_sel + 2'd1;

   // Pattern for the slot about to start; only consumed on the wrap edge.
   always_comb begin
      w_in_next = in0;
      case (w_sel_next)
         2'd0:    w_in_next = in0;
         2'd1:    w_in_next = in1;
         2'd2:    w_in_next = in2;
         default: w_in_next = in3;
      endcase
   end

   always_comb begin
      w_phase_next = r_phase;
      if (w_wrap) begin
         w_phase_next = (BLANK == 0) ? S_SHOW : S_BLANK;
      end else if ((r_phase == S_BLANK) && (w_cnt_next == C_BLANK)) begin
         w_phase_next = S_SHOW;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_phase <= S_BLANK;
      end else begin
         r_phase <= w_phase_next;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt  <= '0;
         r_sel  <= 2'd0;
         r_seg  <= 8'h00;
         r_mask <= 1'b0;
         r_en   <= 1'b0;
         r_tick <= 1'b0;
      end else begin
         r_cnt  <= w_cnt_next;
         r_tick <= w_wrap;
         r_en   <= en_in;
         if (w_wrap) begin
            r_sel  <= w_sel_next;
            r_seg  <= w_in_next;
            r_mask <= mask[w_sel_next];
         end
      end
   end

   // Every term is a flop, so reset clears dec_en without waiting for a clock.
   assign dec_en    = (r_phase == S_SHOW) && r_mask && r_en;
   assign sel       = r_sel;
   assign seg       = r_seg;
   assign slot_tick = r_tick;

endmodule
`default_nettype wire

// File: tb/tb_disp_scan_ctrl.sv
`default_nettype none
// Testbench for disp_scan_ctrl: per-cycle reference model feeds a scoreboard
// queue that a negedge monitor drains and compares against the DUT.
module tb_disp_scan_ctrl;

   localparam int DIV   = 8;
   localparam int BLANK = 2;

   typedef struct packed {
      logic [1:0] sel;
      logic [7:0] seg;
      logic       de;
      logic       tick;
   } rec_t;

   logic       clk     = 1'b0;
   logic       clk_run = 1'b0;
   logic       reset_n = 1'b1;
   logic [7:0] in0 = 8'h00, in1 = 8'h00, in2 = 8'h00, in3 = 8'h00;
   logic [3:0] mask  = 4'h0;
   logic       en_in = 1'b0;
   logic [1:0] sel;
   logic       dec_en;
   logic [7:0] seg;
   logic       slot_tick;

   int   n_pass  = 0;
   int   n_total = 0;
   rec_t exp_q[$];

   // reference model state
   int         m_age  = 0;
   int         m_cnt  = 0;
   int         m_sel  = 0;
   logic [7:0] m_seg  = 8'h00;
   logic       m_mask = 1'b0;
   logic       m_en   = 1'b0;

   disp_scan_ctrl #(.DIV(DIV), .BLANK(BLANK)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .in0       (in0),
      .in1       (in1),
      .in2       (in2),
      .in3       (in3),
      .mask      (mask),
      .en_in     (en_in),
      .sel       (sel),
      .dec_en    (dec_en),
      .seg       (seg),
      .slot_tick (slot_tick)
   );

   always begin
      #5;
      if (clk_run) clk = ~clk;
   end

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      else n_pass++;
   endtask

   always @(negedge reset_n) begin
      m_age = 0; m_cnt = 0; m_sel = 0;
      m_seg = 8'h00; m_mask = 1'b0; m_en = 1'b0;
      exp_q.delete();
   end

   // Model: slot number = cycles since release / DIV; data is sampled at slot start.
   always @(posedge clk) begin
      logic [7:0] ins [4];
      rec_t r;
      if (!reset_n) begin
         r = '{sel: 2'd0, seg: 8'h00, de: 1'b0, tick: 1'b0};
      end else begin
         ins[0] = in0; ins[1] = in1; ins[2] = in2; ins[3] = in3;
         m_age++;
         m_cnt = m_age % DIV;
         m_sel = (m_age / DIV) % 4;
         if (m_cnt == 0) begin
            m_seg  = ins[m_sel];
            m_mask = mask[m_sel];
         end
         m_en = en_in;
         r.sel  = 2'(m_sel);
         r.seg  = m_seg;
         r.de   = (m_cnt >= BLANK) && m_mask && m_en;
         r.tick = (m_cnt == 0);
      end
      exp_q.push_back(r);
   end

   always @(negedge clk) begin
      rec_t r;
      if (exp_q.size() > 0) begin
         r = exp_q.pop_front();
         chk("sel",       {6'b0, sel},       {6'b0, r.sel});
         chk("seg",       seg,               r.seg);
         chk("dec_en",    {7'b0, dec_en},    {7'b0, r.de});
         chk("slot_tick", {7'b0, slot_tick}, {7'b0, r.tick});
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic goto_slot(input int s, input int c);
      int k;
      for (k = 0; k < 100; k++) begin
         step(1);
         if (m_sel == s && m_cnt == c) break;
      end
      if (k == 100) begin
         n_total++;
         $display("FAIL goto_slot: sel=%0d cnt=%0d not reached within 100 cycles", s, c);
      end
   endtask

   initial begin
      // 1. reset with clock stopped
      #3 reset_n = 1'b0;
      #1;
      chk("rst_sel",  {6'b0, sel},       8'h00);
      chk("rst_de",   {7'b0, dec_en},    8'h00);
      chk("rst_seg",  seg,               8'h00);
      chk("rst_tick", {7'b0, slot_tick}, 8'h00);
      clk_run = 1'b1;
      in0 = 8'h3F; in1 = 8'h06; in2 = 8'h5B; in3 = 8'h4F;
      mask = 4'hF; en_in = 1'b1;
      repeat (20) @(posedge clk);
      #2 reset_n = 1'b1;

      // 2. free run
      step(5 * DIV);

      // 3. digit mask
      mask = 4'b0101;
      step(8 * DIV);
      mask = 4'hF;
      step(4 * DIV);

      // 4. no tearing
      goto_slot(2, 4);
      in2 = 8'h7F;
      step(5 * DIV);

      // 5. enable glitch in a lit slot
      goto_slot(1, 4);
      en_in = 1'b0;
      step(1);
      en_in = 1'b1;
      step(2 * DIV);

      // 6. asynchronous reset mid-scan
      goto_slot(2, 5);
      chk("pre_rst_de", {7'b0, dec_en}, 8'h01);
      #1 reset_n = 1'b0;
      #1;
      chk("async_de",   {7'b0, dec_en},    8'h00);
      chk("async_sel",  {6'b0, sel},       8'h00);
      chk("async_seg",  seg,               8'h00);
      chk("async_tick", {7'b0, slot_tick}, 8'h00);
      @(posedge clk);
      #2 reset_n = 1'b1;
      step(5 * DIV);

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         step(1);
         if ($urandom_range(0, 3) == 0) in0 = 8'($urandom);
         if ($urandom_range(0, 3) == 0) in1 = 8'($urandom);
         if ($urandom_range(0, 3) == 0) in2 = 8'($urandom);
         if ($urandom_range(0, 3) == 0) in3 = 8'($urandom);
         if ($urandom_range(0, 7) == 0) mask = 4'($urandom);
         en_in = ($urandom_range(0, 9) != 0);
      end
      @(negedge clk);
      #1;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
